// File: rtl/sort_job_sequencer.sv
// rtl/sort_job_sequencer.sv - load/sort/read-out sequencer around an 8x8 single-port RAM
// Optional sort watchdog and ERR state when SEQ_TIMEOUT_EN is defined.
module sort_job_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       sort_s,
  input  logic       sort_done,
  input  logic [2:0] sort_addr,
  input  logic       sort_we,
  input  logic [7:0] sort_din,
  output logic [2:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout,
`ifdef SEQ_TIMEOUT_EN
  output logic       err,
`endif
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SORT,
    RD,
`ifdef SEQ_TIMEOUT_EN
    ERR,
`endif
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [2:0]  rcnt_q, rcnt_d;
  logic [7:0]  data_q, data_d;
  logic        first_q, first_d;
`ifdef SEQ_TIMEOUT_EN
  logic [7:0]  wd_q, wd_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= 3'd0;
      rcnt_q  <= 3'd0;
      data_q  <= 8'd0;
      first_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_q    <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      data_q  <= data_d;
      first_q <= first_d;
`ifdef SEQ_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  // The RAM read lands during the first HOLD cycle, so that cycle passes ram_dout
  // straight through and the register holds it for any stall that follows.
  assign out_data = first_q ? ram_dout : data_q;
  assign busy     = (state_q != IDLE);
`ifdef SEQ_TIMEOUT_EN
  assign err      = (state_q == ERR);
`endif

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    data_d    = data_q;
    first_d   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    sort_s    = 1'b0;
    ram_addr  = 3'd0;
    ram_we    = 1'b0;
    ram_din   = 8'd0;
`ifdef SEQ_TIMEOUT_EN
    wd_d      = wd_q;
`endif
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_we   = 1'b1;
          ram_addr = wcnt_q;
          ram_din  = in_data;
          wcnt_d   = wcnt_q + 3'd1;
          if (wcnt_q == 3'd7) begin
            state_d = SORT;
`ifdef SEQ_TIMEOUT_EN
            wd_d    = 8'd0;
`endif
          end
        end
      end
      SORT: begin
        sort_s   = 1'b1;
        ram_addr = sort_addr;
        ram_we   = sort_we;
        ram_din  = sort_din;
        if (sort_done) begin
          state_d = RD;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_q == 8'd255) begin
          state_d = ERR;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      RD: begin
        ram_addr = rcnt_q;
        first_d  = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        out_last  = (rcnt_q == 3'd7);
        if (first_q) begin
          data_d = ram_dout;
        end
        if (out_ready) begin
          if (rcnt_q == 3'd7) begin
            rcnt_d  = 3'd0;
            state_d = LOAD;
          end else begin
            rcnt_d  = rcnt_q + 3'd1;
            state_d = RD;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

endmodule
